time_entry_loader: RTL

- Keypad-side writer for the MM:SS timer counter chain.
- Collects BCD digits from the keypad, right-shifting them into four digit registers (min_tens, min_ones, sec_tens, sec_ones).
- Validates the entered time.
- On start, drives a registered active-low load strobe and stable parallel data into the MOD6/MOD10 counters' loadn/data inputs.

---
 rtl/time_entry_loader_pkg.sv | 20 ++
 rtl/time_entry_loader_bcd_digit_shifter.sv | 76 +++++++
 rtl/time_entry_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/time_entry_loader_pkg.sv
// Shared definitions for the keypad time-entry loader: FSM encoding and
// the digit/seconds limits used when validating keypad input.
package time_entry_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } tel_state_e;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

  // True for keypad codes that represent a decimal digit.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= KEY_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/time_entry_loader_bcd_digit_shifter.sv
// Four-digit BCD shift register (min_tens..sec_ones) with a saturating
// count of digits entered. New digits enter at sec_ones and push the
// older ones toward min_tens. Clear wins over shift; freeze blocks shift.
module bcd_digit_shifter
  import time_entry_loader_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       shift_en,
  input  logic       clear,
  input  logic       freeze,
  input  logic [3:0] digit_in,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count
);

  logic [3:0] mt_q, mt_d;
  logic [3:0] mo_q, mo_d;
  logic [3:0] st_q, st_d;
  logic [3:0] so_q, so_d;
  logic [2:0] cnt_q, cnt_d;
  logic       full;

  assign full = (cnt_q >= 3'(MAX_DIGITS));

  // Next-state: clear, shift in a new digit, or hold.
  always_comb begin
    mt_d  = mt_q;
    mo_d  = mo_q;
    st_d  = st_q;
    so_d  = so_q;
    cnt_d = cnt_q;
    if (clear) begin
      mt_d  = 4'd0;
      mo_d  = 4'd0;
      st_d  = 4'd0;
      so_d  = 4'd0;
      cnt_d = 3'd0;
    end else if (shift_en && !freeze && !full) begin
      mt_d  = mo_q;
      mo_d  = st_q;
      st_d  = so_q;
      so_d  = digit_in;
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Digit and count registers.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      mt_q  <= 4'd0;
      mo_q  <= 4'd0;
      st_q  <= 4'd0;
      so_q  <= 4'd0;
      cnt_q <= 3'd0;
    end else begin
      mt_q  <= mt_d;
      mo_q  <= mo_d;
      st_q  <= st_d;
      so_q  <= so_d;
      cnt_q <= cnt_d;
    end
  end

  assign min_tens    = mt_q;
  assign min_ones    = mo_q;
  assign sec_tens    = st_q;
  assign sec_ones    = so_q;
  assign digit_count = cnt_q;

endmodule

// File: rtl/time_entry_loader.sv
// Keypad-side writer for the MM:SS counter chain. Collects digits, checks
// the seconds-tens digit on start, then drives a flop-based active-low load
// strobe for LOAD_CYCLES clocks while the digit outputs are held stable.
module time_entry_loader
  import time_entry_loader_pkg::*;
#(
  parameter int LOAD_CYCLES = 2,
  parameter int MAX_DIGITS  = 4
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_running,
  output logic       loadn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       entry_error,
  output logic       load_done
);

  tel_state_e state_q, state_d;
  logic       loadn_q, loadn_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic [3:0] lcnt_q, lcnt_d;
  logic       shift_en;
  logic       clear;
  logic       freeze;

  // Digits are held through LOAD and the DONE cycle so the counters see
  // stable data while loadn is low and immediately after it rises.
  assign freeze = (state_q == LOAD) || (state_q == DONE);

  bcd_digit_shifter #(
    .MAX_DIGITS(MAX_DIGITS)
  ) u_shifter (
    .clock      (clock),
    .clrn       (clrn),
    .shift_en   (shift_en),
    .clear      (clear),
    .freeze     (freeze),
    .digit_in   (key_code),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .digit_count(digit_count)
  );

  // Next-state and control decode; priority is cancel > start > key.
  always_comb begin
    state_d  = state_q;
    loadn_d  = 1'b1;
    err_d    = err_q;
    done_d   = 1'b0;
    lcnt_d   = lcnt_q;
    shift_en = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      IDLE, ENTRY: begin
        if (cancel) begin
          clear   = 1'b1;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (!timer_running) begin
          if (start) begin
            // Start always consumes the cycle; a simultaneous key is dropped.
            if (state_q == ENTRY) begin
              if (sec_tens > SEC_TENS_MAX) begin
                err_d = 1'b1;
              end else begin
                state_d = LOAD;
                loadn_d = 1'b0;
                lcnt_d  = 4'(LOAD_CYCLES - 1);
              end
            end
          end else if (key_valid) begin
            if (!is_digit(key_code)) begin
              err_d = 1'b1;
            end else if (digit_count < 3'(MAX_DIGITS)) begin
              shift_en = 1'b1;
              state_d  = ENTRY;
            end
          end
        end
      end
      LOAD: begin
        // Cancel is deliberately ignored here so a load is never truncated.
        if (lcnt_q == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          loadn_d = 1'b0;
          lcnt_d  = lcnt_q - 4'd1;
        end
      end
      DONE: begin
        clear   = 1'b1;
        state_d = IDLE;
        if (cancel) begin
          err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; loadn comes straight from a flop for a clean strobe.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      loadn_q <= 1'b1;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      lcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      loadn_q <= loadn_d;
      err_q   <= err_d;
      done_q  <= done_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign loadn       = loadn_q;
  assign entry_error = err_q;
  assign load_done   = done_q;

endmodule
